// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO result registers
// Radix-2 shift-add multiply and restoring divide on magnitudes; sign fix-up in a final cycle.
module mult_div_unit (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [1:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iFlush,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oHi,
    output logic [31:0] oLo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_signed;
    logic        accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] acc_neg;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        is_signed = ~iOp[0];
        accept    = iStart & ~iFlush & ((state_q == S_IDLE) | (state_q == S_DONE));
        a_mag     = (is_signed & iA[31]) ? (32'd0 - iA) : iA;
        b_mag     = (is_signed & iB[31]) ? (32'd0 - iB) : iB;

        // Multiply: acc = {partial, multiplier}, add into the top half then shift right.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        // Divide: acc = {remainder, dividend}, shift left and try to subtract the divisor.
        div_sh    = acc_q[63:31];
        div_ge    = div_sh >= {1'b0, b_q};
        div_sub   = div_sh[31:0] - b_q;
        acc_neg   = 64'd0 - acc_q;

        if (iFlush) begin
            cnt_d = 6'd0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    cnt_d     = 6'd0;
                    is_div_d  = iOp[1];
                    b_d       = b_mag;
                    acc_d     = {32'd0, a_mag};
                    neg_res_d = is_signed & (iA[31] ^ iB[31]);
                    neg_rem_d = is_signed & iOp[1] & iA[31];
                    if (iOp[1] && (iB == 32'd0)) begin
                        state_d = S_DONE;
                        lo_d    = 32'hFFFF_FFFF;
                        hi_d    = iA;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (iFlush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = {(div_ge ? div_sub : div_sh[31:0]), acc_q[30:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (iFlush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (is_div_q) begin
                        lo_d = neg_res_q ? acc_neg[31:0] : acc_q[31:0];
                        hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? acc_neg : acc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            b_q       <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign oBusy = (state_q == S_CALC) | (state_q == S_FIX);
    assign oDone = (state_q == S_DONE);
    assign oHi   = hi_q;
    assign oLo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic [1:0]  iOp = 2'b00;
    logic [31:0] iA = 32'd0;
    logic [31:0] iB = 32'd0;
    logic        iFlush = 1'b0;
    logic        oBusy, oDone;
    logic [31:0] oHi, oLo;

    int checks = 0;
    int failures = 0;

    mult_div_unit dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iStart (iStart),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .iFlush (iFlush),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oHi    (oHi),
        .oLo    (oLo)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request at the current negedge; returns at the negedge where oDone is seen.
    // poke_lat >= 0 drives a stray iStart with different operands during the operation.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat, input int poke_lat);
        int lat;
        int busy;
        iOp = op; iA = a; iB = b; iStart = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iStart = 1'b0; iA = ~a; iB = ~b; iOp = ~op;
        lat = 0;
        busy = 0;
        if (oBusy) busy++;
        while (!oDone && lat < 100) begin
            if (lat == poke_lat) begin
                iStart = 1'b1; iOp = 2'b00; iA = 32'd6; iB = 32'd7;
            end
            @(posedge iCLK);
            lat++;
            @(negedge iCLK);
            iStart = 1'b0;
            if (oBusy) busy++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy), (exp_lat == 0) ? 64'd0 : 64'(exp_lat));
        check({tag, " hi"}, {32'd0, oHi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, oLo}, {32'd0, exp_lo});
    endtask

    initial begin
        int done_seen;

        #1;
        check("reset busy", {63'd0, oBusy}, 64'd0);
        check("reset done", {63'd0, oDone}, 64'd0);
        check("reset hi", {32'd0, oHi}, 64'd0);
        check("reset lo", {32'd0, oLo}, 64'd0);
        iStart = 1'b1; iOp = 2'b11; iA = 32'd5; iB = 32'd0;
        @(posedge iCLK);
        @(negedge iCLK);
        check("start during reset done", {63'd0, oDone}, 64'd0);
        check("start during reset lo", {32'd0, oLo}, 64'd0);
        iStart = 1'b0;
        iRST = 1'b0;
        @(negedge iCLK);

        run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, -1);
        @(posedge iCLK);
        @(negedge iCLK);
        check("mult done pulse width", {63'd0, oDone}, 64'd0);
        check("mult idle busy", {63'd0, oBusy}, 64'd0);

        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, -1);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1);
        run_op("divu 100/7 poke", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 5);
        run_op("div overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, -1);
        run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, -1);
        run_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, -1);
        @(posedge iCLK);
        @(negedge iCLK);

        // Flush at iteration 10, with iStart also high on the flush edge.
        iOp = 2'b01; iA = 32'd3; iB = 32'd3; iStart = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (9) @(negedge iCLK);
        check("flush pre busy", {63'd0, oBusy}, 64'd1);
        iFlush = 1'b1; iStart = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iFlush = 1'b0; iStart = 1'b0;
        check("flush busy", {63'd0, oBusy}, 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (oDone) done_seen++;
        end
        check("flush no done", 64'(done_seen), 64'd0);
        check("flush hi kept", {32'd0, oHi}, {32'd0, 32'hFFFF_FFFB});
        check("flush lo kept", {32'd0, oLo}, {32'd0, 32'hFFFF_FFFF});

        // Flush and start together in IDLE: no acceptance.
        iOp = 2'b11; iA = 32'd9; iB = 32'd0; iStart = 1'b1; iFlush = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iStart = 1'b0; iFlush = 1'b0;
        check("flush+start done", {63'd0, oDone}, 64'd0);
        check("flush+start lo", {32'd0, oLo}, {32'd0, 32'hFFFF_FFFF});
        check("flush+start hi", {32'd0, oHi}, {32'd0, 32'hFFFF_FFFB});

        // Reset at iteration 20.
        iOp = 2'b01; iA = 32'hFFFF_FFFF; iB = 32'hFFFF_FFFF; iStart = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (19) @(negedge iCLK);
        iRST = 1'b1;
        #1;
        check("mid reset busy", {63'd0, oBusy}, 64'd0);
        check("mid reset hi", {32'd0, oHi}, 64'd0);
        check("mid reset lo", {32'd0, oLo}, 64'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        run_op("mult 6*7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 33, -1);
        run_op("b2b divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, -1);
        @(posedge iCLK);
        @(negedge iCLK);
        check("b2b done fall", {63'd0, oDone}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
